// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage and IF/ID register with req/ack imem handshake.
// Optional FETCH_STATS_EN adds fetchCount/bubbleCount counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcD,
  input  logic [31:0] pcBranchD,
  input  logic        jumpD,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic [5:0]  opD,
  output logic [5:0]  functD
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] bubbleCount
`endif
);
  typedef enum logic [1:0] {REQ, HOLD, DROP} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d, buf_instr_q, buf_instr_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d, addr_q, addr_d;
  logic        valid_q, valid_d, req_q, req_d;
  logic        redir, hold, word_ok, load;
  logic [31:0] target, pc_plus4, word;
  assign redir    = (pcSrcD | jumpD) & ~stallD;
  assign target   = pcSrcD ? pcBranchD : {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;
  assign hold     = stallD & ~flushD;
  assign load     = word_ok & ~flushD;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    word_ok     = 1'b0;
    word        = buf_instr_q;
    case (state_q)
      REQ: begin
        word = imemRdata;
        if (imemAck & redir) pc_d = target;
        else if (imemAck & ~stallD) begin
          word_ok = 1'b1;
          pc_d    = pc_plus4;
        end else if (imemAck) begin
          buf_instr_d = imemRdata;
          state_d     = HOLD;
        end else if (redir) begin
          req_addr_d = pc_q;
          pc_d       = target;
          state_d    = DROP;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = REQ;
        end else if (~stallD) begin
          word_ok = 1'b1;
          pc_d    = pc_plus4;
          state_d = REQ;
        end
      end
      DROP: begin
        // the old request stays on the bus until acked; only pcF follows redirects
        if (redir) pc_d = target;
        if (imemAck) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    instr_d = load ? word : hold ? instr_q : '0;
    valid_d = load ? 1'b1 : hold & valid_q;
    pc4_d   = load ? pc_plus4 : pc4_q;
    req_d   = state_d != HOLD;
    addr_d  = state_d == DROP ? req_addr_d : pc_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= '0;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b1;
      addr_q      <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
    end
  end
  assign imemReq  = req_q;
  assign imemAddr = addr_q;
  assign instrD   = instr_q;
  assign pcPlus4D = pc4_q;
  assign validD   = valid_q;
  assign opD      = instr_q[31:26];
  assign functD   = instr_q[5:0];
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, load};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~hold & ~load};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign fetchCount  = fetch_cnt_q;
  assign bubbleCount = bubble_cnt_q;
`endif
endmodule
